// File: rtl/ps2_pkg.sv
// Shared types and protocol constants for the PS/2 LED command sequencer.
package ps2_pkg;

    typedef enum logic [3:0] {
        IDLE,
        TX_CMD,
        WAIT_TX_CMD,
        WAIT_ACK_CMD,
        TX_ARG,
        WAIT_TX_ARG,
        WAIT_ACK_ARG,
        DONE,
        FAIL
    } ps2_state_e;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_RSP_ACK     = 8'hFA;
    localparam logic [7:0] PS2_RSP_RESEND  = 8'hFE;

endpackage

// File: rtl/ps2_cmd_sequencer_if.sv
// Byte-level link between the command sequencer (master) and the PS/2 line controller (slave).
interface ps2_cmd_sequencer_if;

    logic [7:0] ps2_cmd;
    logic       ps2_send;
    logic       ps2_cmd_sent;
    logic       ps2_cmd_timeout;
    logic [7:0] ps2_rx_data;
    logic       ps2_rx_en;

    modport master (
        output ps2_cmd, ps2_send,
        input  ps2_cmd_sent, ps2_cmd_timeout, ps2_rx_data, ps2_rx_en
    );

    modport slave (
        input  ps2_cmd, ps2_send,
        output ps2_cmd_sent, ps2_cmd_timeout, ps2_rx_data, ps2_rx_en
    );

endinterface

// File: rtl/ps2_ack_timer.sv
// Clearable saturating up-counter; tc flags that the count has reached TC_VAL.
module ps2_ack_timer #(
    parameter int unsigned CW     = 7,
    parameter int unsigned TC_VAL = 99
) (
    input  logic CLK_50,
    input  logic RESET,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK_50) begin
        if (RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == CW'(TC_VAL));

endmodule

// File: rtl/ps2_cmd_sequencer.sv
// PS/2 keyboard LED writer: sends ED then the LED byte, waits for FA acks, forwards scancodes.
// Build option PS2_CMD_RETRY_EN: resend a byte on FE up to MAX_RETRY times instead of failing.
module ps2_cmd_sequencer
    import ps2_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT_CYCLES = 1000000,
    parameter int unsigned MAX_RETRY          = 3
) (
    input  logic                       CLK_50,
    input  logic                       RESET,
    input  logic                       led_req,
    input  logic [2:0]                 led_val,
    output logic                       led_busy,
    output logic                       led_done,
    output logic                       led_err,
    output logic [7:0]                 KEYCODE_OUT,
    output logic                       KEYCODE_RDY,
    ps2_cmd_sequencer_if.master        ps2
);

    localparam int unsigned TW = (ACK_TIMEOUT_CYCLES > 1) ? $clog2(ACK_TIMEOUT_CYCLES) : 1;
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
`ifdef PS2_CMD_RETRY_EN
    localparam int unsigned RETRY_LIMIT = MAX_RETRY;
`else
    localparam int unsigned RETRY_LIMIT = 0;
`endif

    ps2_state_e    state_q, state_d;
    logic [7:0]    arg_q, arg_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [7:0]    kc_q, kc_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          send_q, send_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          rdy_q, rdy_d;
    logic          ack_wait, ack_tc, timer_clr;

    assign ack_wait  = (state_q == WAIT_ACK_CMD) || (state_q == WAIT_ACK_ARG);
    assign timer_clr = (state_d != state_q);

    ps2_ack_timer #(
        .CW     (TW),
        .TC_VAL (ACK_TIMEOUT_CYCLES - 1)
    ) u_ack_timer (
        .CLK_50 (CLK_50),
        .RESET  (RESET),
        .clr    (timer_clr),
        .en     (ack_wait),
        .tc     (ack_tc)
    );

    always_comb begin
        state_d = state_q;
        arg_d   = arg_q;
        kc_d    = kc_q;
        rdy_d   = 1'b0;
        retry_d = retry_q;
        case (state_q)
            IDLE: begin
                retry_d = '0;
                if (led_req) begin
                    arg_d   = {5'b0, led_val};
                    state_d = TX_CMD;
                end
                if (ps2.ps2_rx_en) begin
                    kc_d  = ps2.ps2_rx_data;
                    rdy_d = 1'b1;
                end
            end
            TX_CMD: state_d = WAIT_TX_CMD;
            TX_ARG: state_d = WAIT_TX_ARG;
            WAIT_TX_CMD, WAIT_TX_ARG: begin
                if (ps2.ps2_cmd_timeout) begin
                    state_d = FAIL;
                end else if (ps2.ps2_cmd_sent) begin
                    state_d = (state_q == WAIT_TX_CMD) ? WAIT_ACK_CMD : WAIT_ACK_ARG;
                end
            end
            WAIT_ACK_CMD, WAIT_ACK_ARG: begin
                // A response byte wins over a timeout landing in the same cycle
                if (ps2.ps2_rx_en) begin
                    if (ps2.ps2_rx_data == PS2_RSP_ACK) begin
                        retry_d = '0;
                        state_d = (state_q == WAIT_ACK_CMD) ? TX_ARG : DONE;
                    end else if (ps2.ps2_rx_data == PS2_RSP_RESEND) begin
                        if (retry_q == RW'(RETRY_LIMIT)) begin
                            state_d = FAIL;
                        end else begin
                            retry_d = retry_q + 1'b1;
                            state_d = (state_q == WAIT_ACK_CMD) ? TX_CMD : TX_ARG;
                        end
                    end else begin
                        kc_d    = ps2.ps2_rx_data;
                        rdy_d   = 1'b1;
                        state_d = FAIL;
                    end
                end else if (ack_tc) begin
                    state_d = FAIL;
                end
            end
            DONE, FAIL: begin
                retry_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        cmd_d = cmd_q;
        if (state_d == TX_CMD) begin
            cmd_d = PS2_CMD_SET_LED;
        end else if (state_d == TX_ARG) begin
            cmd_d = arg_d;
        end
        send_d = (state_d == TX_CMD) || (state_d == TX_ARG);
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        err_d  = (state_d == FAIL);
    end

    always_ff @(posedge CLK_50) begin
        if (RESET) begin
            state_q <= IDLE;
            arg_q   <= 8'h00;
            cmd_q   <= 8'h00;
            kc_q    <= 8'h00;
            retry_q <= '0;
            send_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            arg_q   <= arg_d;
            cmd_q   <= cmd_d;
            kc_q    <= kc_d;
            retry_q <= retry_d;
            send_q  <= send_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdy_q   <= rdy_d;
        end
    end

    assign ps2.ps2_cmd  = cmd_q;
    assign ps2.ps2_send = send_q;
    assign led_busy     = busy_q;
    assign led_done     = done_q;
    assign led_err      = err_q;
    assign KEYCODE_OUT  = kc_q;
    assign KEYCODE_RDY  = rdy_q;

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Bench for ps2_cmd_sequencer: emulated keyboard answers from a response script, checked against a script-level model.
`timescale 1ns/1ps
module tb_ps2_cmd_sequencer;

    localparam int ACK_TO = 100;
    localparam int MAX_RT = 3;
`ifdef PS2_CMD_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    logic       CLK_50 = 1'b0;
    logic       RESET  = 1'b1;
    logic       led_req = 1'b0;
    logic [2:0] led_val = 3'b000;
    logic       led_busy, led_done, led_err;
    logic [7:0] KEYCODE_OUT;
    logic       KEYCODE_RDY;

    ps2_cmd_sequencer_if ps2 ();

    ps2_cmd_sequencer #(
        .ACK_TIMEOUT_CYCLES (ACK_TO),
        .MAX_RETRY          (MAX_RT)
    ) dut (
        .CLK_50      (CLK_50),
        .RESET       (RESET),
        .led_req     (led_req),
        .led_val     (led_val),
        .led_busy    (led_busy),
        .led_done    (led_done),
        .led_err     (led_err),
        .KEYCODE_OUT (KEYCODE_OUT),
        .KEYCODE_RDY (KEYCODE_RDY),
        .ps2         (ps2)
    );

    always #10 CLK_50 = ~CLK_50;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int n_done = 0;
    int n_err = 0;
    int t_err = 0;
    logic [7:0] sent_q[$];
    logic [7:0] kc_q[$];

    // Scripted device responses and the model's expectations for one sequence
    logic [7:0] rsp_q[$];
    logic [7:0] exp_s_q[$];
    logic [7:0] exp_kc_q[$];
    int exp_done, exp_err;

    int n, base_s, base_kc, base_done, base_err;
    logic [7:0] b;

    always @(posedge CLK_50) cyc <= cyc + 1;

    always @(negedge CLK_50) begin
        if (ps2.ps2_send) sent_q.push_back(ps2.ps2_cmd);
        if (KEYCODE_RDY) kc_q.push_back(KEYCODE_OUT);
        if (led_done) n_done++;
        if (led_err) begin
            n_err++;
            t_err = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Walk the response script byte by byte: what gets sent, forwarded, and how it ends
    task automatic model_seq(input logic [2:0] val, input bit tx_to);
        int stage, retries, i;
        bit fin;
        logic [7:0] r;
        stage = 0; retries = 0; i = 0; fin = 1'b0;
        exp_s_q.delete();
        exp_kc_q.delete();
        exp_done = 0;
        exp_err = 0;
        while (!fin) begin
            exp_s_q.push_back((stage == 0) ? 8'hED : {5'b0, val});
            if (tx_to || i >= rsp_q.size()) begin
                exp_err = 1;
                fin = 1'b1;
            end else begin
                r = rsp_q[i];
                i++;
                if (r == 8'hFA) begin
                    if (stage == 0) begin
                        stage = 1;
                        retries = 0;
                    end else begin
                        exp_done = 1;
                        fin = 1'b1;
                    end
                end else if (r == 8'hFE) begin
                    if (RETRY_EN && retries < MAX_RT) retries++;
                    else begin
                        exp_err = 1;
                        fin = 1'b1;
                    end
                end else begin
                    exp_kc_q.push_back(r);
                    exp_err = 1;
                    fin = 1'b1;
                end
            end
        end
    endtask

    task automatic run_seq(input logic [2:0] val, input bit tx_to, input bit chk_lat);
        int phase, dly, idx, budget, t_sent, d;
        bit fin;
        phase = 0; dly = 0; idx = 0; budget = 0; t_sent = 0; fin = 1'b0;
        model_seq(val, tx_to);
        @(negedge CLK_50);
        base_s = sent_q.size();
        base_kc = kc_q.size();
        base_done = n_done;
        base_err = n_err;
        led_val = val;
        led_req = 1'b1;
        @(negedge CLK_50);
        led_req = 1'b0;
        check("busy_rise", 32'(led_busy), 1);
        while (!fin && budget < 600) begin
            ps2.ps2_cmd_sent = 1'b0;
            ps2.ps2_cmd_timeout = 1'b0;
            ps2.ps2_rx_en = 1'b0;
            led_req = 1'b0;
            if (led_done || led_err) begin
                fin = 1'b1;
            end else begin
                case (phase)
                    0: if (ps2.ps2_send) begin
                        phase = 1;
                        dly = $urandom_range(1, 3);
                    end
                    1: begin
                        dly--;
                        if (dly == 0) begin
                            if (tx_to) ps2.ps2_cmd_timeout = 1'b1;
                            else ps2.ps2_cmd_sent = 1'b1;
                            t_sent = cyc;
                            phase = 2;
                            dly = $urandom_range(1, 4);
                        end
                    end
                    default: begin
                        dly--;
                        if (dly == 0) begin
                            if (idx < rsp_q.size()) begin
                                ps2.ps2_rx_data = rsp_q[idx];
                                ps2.ps2_rx_en = 1'b1;
                                idx++;
                            end
                            phase = 0;
                        end
                    end
                endcase
                // A request while busy must be dropped
                if (budget == 2) begin
                    led_req = 1'b1;
                    led_val = 3'($urandom);
                end
            end
            budget++;
            if (!fin) @(negedge CLK_50);
        end
        check("seq_finished", 32'(fin), 1);
        @(negedge CLK_50);
        check("busy_fall", 32'(led_busy), 0);
        @(negedge CLK_50);
        check("send_count", 32'(sent_q.size() - base_s), 32'(exp_s_q.size()));
        for (int k = 0; k < exp_s_q.size(); k++) begin
            if (base_s + k < sent_q.size())
                check("send_byte", 32'(sent_q[base_s + k]), 32'(exp_s_q[k]));
        end
        check("done_pulses", 32'(n_done - base_done), 32'(exp_done));
        check("err_pulses", 32'(n_err - base_err), 32'(exp_err));
        check("kc_count", 32'(kc_q.size() - base_kc), 32'(exp_kc_q.size()));
        for (int k = 0; k < exp_kc_q.size(); k++) begin
            if (base_kc + k < kc_q.size())
                check("kc_byte", 32'(kc_q[base_kc + k]), 32'(exp_kc_q[k]));
        end
        if (chk_lat) begin
            d = t_err - (t_sent + 1);
            check("ack_timeout_latency", 32'((d >= ACK_TO - 1) && (d <= ACK_TO + 1)), 1);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ps2.ps2_cmd_sent = 1'b0;
        ps2.ps2_cmd_timeout = 1'b0;
        ps2.ps2_rx_data = 8'h00;
        ps2.ps2_rx_en = 1'b0;
        RESET = 1'b1;
        repeat (3) @(negedge CLK_50);
        RESET = 1'b0;
        @(negedge CLK_50);
        check("rst_busy", 32'(led_busy), 0);
        check("rst_done", 32'(led_done), 0);
        check("rst_err", 32'(led_err), 0);
        check("rst_send", 32'(ps2.ps2_send), 0);
        check("rst_cmd", 32'(ps2.ps2_cmd), 0);
        check("rst_kc", 32'(KEYCODE_OUT), 0);
        check("rst_rdy", 32'(KEYCODE_RDY), 0);

        // Bytes arriving while idle are all forwarded, including FA/FE
        for (int i = 0; i < 5; i++) begin
            b = (i == 0) ? 8'h1C : (i == 1) ? 8'hFA : 8'($urandom);
            ps2.ps2_rx_data = b;
            ps2.ps2_rx_en = 1'b1;
            @(negedge CLK_50);
            ps2.ps2_rx_en = 1'b0;
            check("idle_kc_rdy", 32'(KEYCODE_RDY), 1);
            check("idle_kc_val", 32'(KEYCODE_OUT), 32'(b));
            check("idle_busy", 32'(led_busy), 0);
            @(negedge CLK_50);
            check("idle_rdy_pulse", 32'(KEYCODE_RDY), 0);
        end

        rsp_q = '{8'hFA, 8'hFA};
        run_seq(3'b101, 1'b0, 1'b0);

        rsp_q = '{8'hFE, 8'hFE, 8'hFE, 8'hFA, 8'hFA};
        run_seq(3'b110, 1'b0, 1'b0);

        rsp_q = '{8'hFA, 8'hFE, 8'hFE, 8'hFE, 8'hFE};
        run_seq(3'b011, 1'b0, 1'b0);

        rsp_q.delete();
        run_seq(3'b001, 1'b0, 1'b1);

        rsp_q = '{8'h1C};
        run_seq(3'b111, 1'b0, 1'b0);

        rsp_q = '{8'hFA, 8'hFA};
        run_seq(3'b101, 1'b1, 1'b0);

        // Reset while waiting for the argument byte to go out
        @(negedge CLK_50);
        base_err = n_err;
        led_val = 3'b011;
        led_req = 1'b1;
        @(negedge CLK_50);
        led_req = 1'b0;
        n = 0;
        while (!ps2.ps2_send && n < 20) begin
            @(negedge CLK_50);
            n++;
        end
        check("mid_cmd_send", 32'(ps2.ps2_cmd), 32'hED);
        @(negedge CLK_50);
        ps2.ps2_cmd_sent = 1'b1;
        @(negedge CLK_50);
        ps2.ps2_cmd_sent = 1'b0;
        ps2.ps2_rx_data = 8'hFA;
        ps2.ps2_rx_en = 1'b1;
        @(negedge CLK_50);
        ps2.ps2_rx_en = 1'b0;
        n = 0;
        while (!ps2.ps2_send && n < 20) begin
            @(negedge CLK_50);
            n++;
        end
        check("mid_arg_send", 32'(ps2.ps2_cmd), 32'h03);
        @(negedge CLK_50);
        check("mid_busy", 32'(led_busy), 1);
        RESET = 1'b1;
        @(negedge CLK_50);
        RESET = 1'b0;
        check("mid_rst_busy", 32'(led_busy), 0);
        check("mid_rst_err", 32'(led_err), 0);
        check("mid_rst_send", 32'(ps2.ps2_send), 0);
        check("mid_rst_cmd", 32'(ps2.ps2_cmd), 0);
        check("mid_rst_kc", 32'(KEYCODE_OUT), 0);
        check("mid_rst_rdy", 32'(KEYCODE_RDY), 0);
        repeat (3) @(negedge CLK_50);
        check("mid_rst_no_err", 32'(n_err - base_err), 0);

        rsp_q = '{8'hFA, 8'hFA};
        run_seq(3'b010, 1'b0, 1'b0);

        for (int s = 0; s < 12; s++) begin
            rsp_q.delete();
            n = $urandom_range(1, 7);
            for (int k = 0; k < n; k++) begin
                int unsigned p;
                p = $urandom_range(0, 99);
                if (p < 60) rsp_q.push_back(8'hFA);
                else if (p < 85) rsp_q.push_back(8'hFE);
                else begin
                    b = 8'($urandom);
                    if (b == 8'hFA || b == 8'hFE) b = 8'h2B;
                    rsp_q.push_back(b);
                end
            end
            run_seq(3'($urandom), 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
